// File: rtl/matmul_seq_engine.sv
// ----------------------------------------------------------------------------
// matmul_seq_engine
//
// Purpose:
//   Sequential NxN integer matrix multiplier. The host writes operand
//   matrices A and B one element at a time, pulses start, and reads
//   C = A x B back by index once done pulses. One multiply-accumulate unit
//   is time-shared, so a full product takes N^3 cycles (one MAC per cycle).
//
// Build option:
//   MATMUL_SIGNED_EN  - when defined, A/B elements are two's-complement and
//                       C is a sign-extended RW-bit signed value. When not
//                       defined, everything is unsigned and zero-extended.
//
// Parameters:
//   N   matrix dimension (>= 2)
//   DW  operand element width
//   IW  element index width, $clog2(N*N) (derived)
//   RW  result element width, 2*DW+$clog2(N) (derived)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous active-low reset
//   load_en     write load_data into the selected operand store
//   load_sel_b  0 = load matrix A, 1 = load matrix B
//   load_addr   row-major element index (row*N+col) for the load
//   load_data   element value for the load
//   start       begin a multiplication (sampled while idle)
//   busy        high for the N^3 compute cycles
//   done        one-cycle pulse once C is complete
//   rd_addr     row-major index into C
//   rd_data     C[rd_addr], combinational; 0 for out-of-range indices
// ----------------------------------------------------------------------------
module matmul_seq_engine #(
  parameter  int N  = 2,
  parameter  int DW = 8,
  localparam int IW = $clog2(N*N),
  localparam int RW = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic          load_sel_b,
  input  logic [IW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [IW-1:0] rd_addr,
  output logic [RW-1:0] rd_data
);

  localparam int NN = N*N;
  localparam int CW = $clog2(N);  // width of the i/j/k loop counters
  localparam int PW = 2*DW;       // full-precision product width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [RW-1:0]   acc_reg;
  logic [CW-1:0]   i_reg;
  logic [CW-1:0]   j_reg;
  logic [CW-1:0]   k_reg;

  logic [DW-1:0]   a_mem [NN];
  logic [DW-1:0]   b_mem [NN];
  logic [RW-1:0]   c_mem [NN];

  // --------------------------------------------------------------------------
  // Datapath: address generation and the shared MAC
  // --------------------------------------------------------------------------
  logic [IW-1:0]   a_idx;
  logic [IW-1:0]   b_idx;
  logic [IW-1:0]   c_idx;
  logic [DW-1:0]   a_elem;
  logic [DW-1:0]   b_elem;
  logic [PW-1:0]   product;
  logic [RW-1:0]   prod_ext;
  logic [RW-1:0]   sum_next;
  logic            k_last;
  logic            j_last;
  logic            i_last;
  logic            c_we;
  logic            load_ok;

  assign a_idx  = IW'(int'(i_reg) * N + int'(k_reg));
  assign b_idx  = IW'(int'(k_reg) * N + int'(j_reg));
  assign c_idx  = IW'(int'(i_reg) * N + int'(j_reg));
  assign a_elem = a_mem[a_idx];
  assign b_elem = b_mem[b_idx];

`ifdef MATMUL_SIGNED_EN
  // Operands are widened by sign extension so the product is exact in PW bits,
  // then the product is sign-extended into the accumulator width.
  assign product  = PW'($signed({{DW{a_elem[DW-1]}}, a_elem}) *
                        $signed({{DW{b_elem[DW-1]}}, b_elem}));
  assign prod_ext = {{(RW-PW){product[PW-1]}}, product};
`else
  assign product  = {{DW{1'b0}}, a_elem} * {{DW{1'b0}}, b_elem};
  assign prod_ext = {{(RW-PW){1'b0}}, product};
`endif

  // Two's-complement addition is the same operation for both builds; RW
  // leaves room for N products so no overflow is possible.
  assign sum_next = acc_reg + prod_ext;

  assign k_last = (k_reg == CW'(N-1));
  assign j_last = (j_reg == CW'(N-1));
  assign i_last = (i_reg == CW'(N-1));

  // C[i][j] is written on the final k step of each dot product.
  assign c_we   = (state_reg == ST_RUN) && k_last;

  // Operand stores are frozen only while computing; DONE still accepts loads.
  assign load_ok = load_en && (state_reg != ST_RUN) && (int'(load_addr) < NN);

  // --------------------------------------------------------------------------
  // Storage: one register per element so every entry clears on reset
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NN; gi++) begin : g_store
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a_mem[gi] <= '0;
        b_mem[gi] <= '0;
        c_mem[gi] <= '0;
      end else begin
        if (load_ok && !load_sel_b && (load_addr == IW'(gi))) begin
          a_mem[gi] <= load_data;
        end
        if (load_ok && load_sel_b && (load_addr == IW'(gi))) begin
          b_mem[gi] <= load_data;
        end
        if (c_we && (c_idx == IW'(gi))) begin
          c_mem[gi] <= sum_next;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered busy/done
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      acc_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            acc_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!k_last) begin
            acc_reg <= sum_next;
            k_reg   <= k_reg + CW'(1);
          end else begin
            // Dot product complete: the store write happens in g_store.
            acc_reg <= '0;
            k_reg   <= '0;
            if (!j_last) begin
              j_reg <= j_reg + CW'(1);
            end else begin
              j_reg <= '0;
              if (!i_last) begin
                i_reg <= i_reg + CW'(1);
              end else begin
                i_reg     <= '0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here; a held start
          // re-triggers from IDLE on the following cycle.
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rd_data = (int'(rd_addr) < NN) ? c_mem[rd_addr] : '0;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// ----------------------------------------------------------------------------
// tb_matmul_seq_engine
//
// Self-checking bench for matmul_seq_engine at its default size (N=2, DW=8).
// Fixed vectors live in a table; random matrices are checked against a plain
// nested-loop matrix product. Hand sequences cover ignored inputs during a
// run, held start, and reset both at rest and mid-run.
// Honours MATMUL_SIGNED_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_matmul_seq_engine;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int NN    = N*N;
  localparam int IW    = $clog2(NN);
  localparam int RW    = 2*DW + $clog2(N);
  localparam int NCUBE = N*N*N;
  localparam int BOUND = 200;

  logic          clk;
  logic          reset;
  logic          load_en;
  logic          load_sel_b;
  logic [IW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] rd_addr;
  logic [RW-1:0] rd_data;

  int checks;
  int errors;

  matmul_seq_engine #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_sel_b (load_sel_b),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [NN*DW-1:0]  a;
    logic [NN*DW-1:0]  b;
    logic [NN*RW-1:0]  c;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      $display("ok   %s: %0h", name, actual);
    end
  endtask

  // Value of one element as the host intends it (signed or unsigned).
  function automatic longint elem_val(input logic [DW-1:0] v);
`ifdef MATMUL_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  // Reference: textbook C[i][j] = sum_k A[i][k]*B[k][j], reduced to RW bits.
  function automatic logic [NN*RW-1:0] model(input logic [NN*DW-1:0] a,
                                             input logic [NN*DW-1:0] b);
    logic [NN*RW-1:0] c;
    longint s;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          s += elem_val(a[(i*N+k)*DW +: DW]) * elem_val(b[(k*N+j)*DW +: DW]);
        end
        c[(i*N+j)*RW +: RW] = s[RW-1:0];
      end
    end
    return c;
  endfunction

  // All tasks begin and end just after a falling edge.
  task automatic load_elem(input logic sel_b, input int addr, input logic [DW-1:0] data);
    load_en    = 1'b1;
    load_sel_b = sel_b;
    load_addr  = IW'(addr);
    load_data  = data;
    @(negedge clk);
    load_en    = 1'b0;
  endtask

  task automatic load_all(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
    for (int e = 0; e < NN; e++) load_elem(1'b0, e, a[e*DW +: DW]);
    for (int e = 0; e < NN; e++) load_elem(1'b1, e, b[e*DW +: DW]);
  endtask

  task automatic check_c(input string name, input logic [NN*RW-1:0] exp_c);
    for (int e = 0; e < NN; e++) begin
      rd_addr = IW'(e);
      #1;
      check($sformatf("%s C[%0d]", name, e), 32'(rd_data), 32'(exp_c[e*RW +: RW]));
    end
  endtask

  // One-cycle start; checks busy length, done pulse shape and single pulse.
  task automatic run_check(input string name);
    int busy_cnt;
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (!done && cyc < BOUND) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s done seen", name), 32'(cyc < BOUND), 32'd1);
    check($sformatf("%s busy cycles", name), 32'(busy_cnt), 32'(NCUBE));
    check($sformatf("%s busy low at done", name), 32'(busy), 32'd0);
    @(negedge clk);
    check($sformatf("%s done one cycle", name), 32'(done), 32'd0);
  endtask

  logic [NN*DW-1:0] ra;
  logic [NN*DW-1:0] rb;
  logic [NN*RW-1:0] basic_c;
  int               done_cnt;
  int               first_done;
  int               second_done;
  int               busy_seen;
  int               activity;

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    load_en    = 1'b0;
    load_sel_b = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    start      = 1'b0;
    rd_addr    = '0;

    // Fixed vectors (element 0 in the low bits, row-major).
    vecs[0].name = "basic";
    vecs[0].a    = {8'd4, 8'd3, 8'd2, 8'd1};
    vecs[0].b    = {8'd8, 8'd7, 8'd6, 8'd5};
    vecs[0].c    = {17'd50, 17'd43, 17'd22, 17'd19};
    vecs[1].name = "max";
    vecs[1].a    = {4{8'hFF}};
    vecs[1].b    = {4{8'hFF}};
`ifdef MATMUL_SIGNED_EN
    vecs[1].c    = {4{17'h00002}};
`else
    vecs[1].c    = {4{17'h1FC02}};
`endif
    vecs[2].name = "sign";
    vecs[2].a    = {4{8'hFF}};
    vecs[2].b    = {4{8'h02}};
`ifdef MATMUL_SIGNED_EN
    vecs[2].c    = {4{17'h1FFFC}};
`else
    vecs[2].c    = {4{17'h003FC}};
`endif
    basic_c = vecs[0].c;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset with populated stores and a non-zero C.
    for (int e = 0; e < NN*DW; e += 8) begin
      ra[e +: 8] = 8'($urandom_range(1, 255));
      rb[e +: 8] = 8'($urandom_range(1, 255));
    end
    load_all(ra, rb);
    run_check("pre-reset");
    reset = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_c("reset", '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // Operand stores must be cleared too: a product of cleared stores is 0.
    run_check("after-reset");
    check_c("after-reset", '0);

    // Table-driven vectors.
    for (int v = 0; v < 3; v++) begin
      load_all(vecs[v].a, vecs[v].b);
      run_check(vecs[v].name);
      check_c(vecs[v].name, vecs[v].c);
    end

    // Random matrices against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < NN*DW; e += 8) begin
        ra[e +: 8] = 8'($urandom);
        rb[e +: 8] = 8'($urandom);
      end
      load_all(ra, rb);
      run_check($sformatf("rand%0d", r));
      check_c($sformatf("rand%0d", r), model(ra, rb));
    end

    // Load and start in the same idle cycle: the new value is used.
    load_all(vecs[0].a, vecs[0].b);
    load_en = 1'b1; load_sel_b = 1'b0; load_addr = '0; load_data = 8'd2;
    start = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start = 1'b0;
    ra = vecs[0].a;
    ra[7:0] = 8'd2;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("same-cycle load done count", 32'(done_cnt), 32'd1);
    check_c("same-cycle load", model(ra, vecs[0].b));

    // Loads and start while busy are ignored.
    load_elem(1'b0, 0, 8'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    load_elem(1'b0, 0, 8'd9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("busy-ignore done count", 32'(done_cnt), 32'd1);
    check_c("busy-ignore", basic_c);
    run_check("busy-ignore rerun");
    check_c("busy-ignore rerun", basic_c);

    // Held start re-triggers on the first idle cycle after DONE.
    start = 1'b1;
    @(negedge clk);
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 25; c++) begin
      if (done) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("held start first done", 32'(first_done), 32'(NCUBE + 1));
    check("held start second done", 32'(second_done), 32'(2*NCUBE + 3));
    busy_seen = 0;
    while ((busy || done) && busy_seen < BOUND) begin
      @(negedge clk);
      busy_seen++;
    end
    check("held start settles", 32'(busy_seen < BOUND), 32'd1);

    // Reset on the 4th busy cycle aborts the run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-run still busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid-run reset busy", 32'(busy), 32'd0);
    check("mid-run reset done", 32'(done), 32'd0);
    check_c("mid-run reset", '0);
    @(negedge clk);
    reset = 1'b1;
    activity = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) activity++;
    end
    check("mid-run no done after abort", 32'(activity), 32'd0);
    check_c("mid-run after abort", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
